// File: rtl/timer.sv
// Memory-mapped interval timer: bus-accessible CTRL/INTR/EXPR/COUNT registers,
// a free-running counter with expiry compare, and a level interrupt.
module timer #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    output logic              irq
);

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_INTR  = 2'd1;
    localparam logic [1:0] REG_EXPR  = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    // The register index only needs two bits of the word address; a bus narrower
    // than the chip-select field plus the index cannot host this slave.
    if (ADDR_W < 5) begin : g_addr_w_check
        $error("timer: ADDR_W too small for chip-select and register index");
    end
    if (DATA_W < 8) begin : g_data_w_check
        $error("timer: DATA_W must be at least 8");
    end

    logic              start_reg,    start_next;
    logic              periodic_reg, periodic_next;
    logic              irq_reg,      irq_next;
    logic [DATA_W-1:0] expr_reg,     expr_next;
    logic [DATA_W-1:0] count_reg,    count_next;
    logic [DATA_W-1:0] rd_data_reg,  rd_data_next;
    logic              rdy_n_reg,    rdy_n_next;

    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic              expire;
    logic [3:0]        wr_sel;
    logic [DATA_W-1:0] reg_val;

    assign accept = !cs_ && !as_;
    assign wr_en  = accept && !rw;
    assign rd_en  = accept && rw;

    // Compare uses the counter value held during this cycle, so a same-cycle
    // COUNT write cannot mask or fake an expiry.
    assign expire = start_reg && (count_reg == expr_reg);

    // One write strobe per register index.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_en && (addr == 2'(gi));
    end

    // Read multiplexer over the pre-write register contents.
    always_comb begin
        reg_val = '0;
        case (addr)
            REG_CTRL:  reg_val = {{(DATA_W-2){1'b0}}, periodic_reg, start_reg};
            REG_INTR:  reg_val = {{(DATA_W-1){1'b0}}, irq_reg};
            REG_EXPR:  reg_val = expr_reg;
            REG_COUNT: reg_val = count_reg;
            default:   reg_val = '0;
        endcase
    end

    // Next-state logic: counting/expiry first, bus writes override where they
    // win, and expiry's IRQ set is applied last so it beats a clearing write.
    always_comb begin
        start_next    = start_reg;
        periodic_next = periodic_reg;
        irq_next      = irq_reg;
        expr_next     = expr_reg;
        count_next    = count_reg;

        if (start_reg) begin
            count_next = expire ? '0 : count_reg + 1'b1;
        end
        if (expire && !periodic_reg) begin
            start_next = 1'b0;
        end

        if (wr_sel[REG_CTRL]) begin
            start_next    = wr_data[0];
            periodic_next = wr_data[1];
        end
        if (wr_sel[REG_INTR]) begin
            irq_next = wr_data[0];
        end
        if (wr_sel[REG_EXPR]) begin
            expr_next = wr_data;
        end
        if (wr_sel[REG_COUNT]) begin
            count_next = wr_data;
        end

        if (expire) begin
            irq_next = 1'b1;
        end
    end

    // Bus response: one ready cycle per accepted access; data only on reads.
    always_comb begin
        rd_data_next = '0;
        rdy_n_next   = !accept;
        if (rd_en) begin
            rd_data_next = reg_val;
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_reg    <= 1'b0;
            periodic_reg <= 1'b0;
            irq_reg      <= 1'b0;
            expr_reg     <= '0;
            count_reg    <= '0;
            rd_data_reg  <= '0;
            rdy_n_reg    <= 1'b1;
        end else begin
            start_reg    <= start_next;
            periodic_reg <= periodic_next;
            irq_reg      <= irq_next;
            expr_reg     <= expr_next;
            count_reg    <= count_next;
            rd_data_reg  <= rd_data_next;
            rdy_n_reg    <= rdy_n_next;
        end
    end

    assign rd_data = rd_data_reg;
    assign rdy_    = rdy_n_reg;
    assign irq     = irq_reg;

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: a register-access vector table followed by
// hand-timed sequences for counting, expiry, priority and reset corners.
module tb_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cs_n;
        logic        as_n;
        logic        rw;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        exp_rdy_n;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[16];

    timer #(.ADDR_W(30), .DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs_     (cs_),
        .as_     (as_),
        .rw      (rw),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rdy_    (rdy_),
        .irq     (irq)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs_     = 1'b1;
        as_     = 1'b1;
        rw      = 1'b1;
        addr    = 2'd0;
        wr_data = 32'h0;
    endtask

    // One bus cycle; outputs are sampled 1 time unit after the closing edge.
    task automatic bus(input logic c, input logic a, input logic r,
                       input logic [1:0] ad, input logic [31:0] d);
        cs_     = c;
        as_     = a;
        rw      = r;
        addr    = ad;
        wr_data = d;
        tick();
        $display("bus cs_=%0b as_=%0b rw=%0b addr=%0d wdata=%h -> rdy_=%0b rd_data=%h irq=%0b",
                 c, a, r, ad, d, rdy_, rd_data, irq);
    endtask

    task automatic wr(input logic [1:0] ad, input logic [31:0] d);
        bus(1'b0, 1'b0, 1'b0, ad, d);
        idle();
    endtask

    task automatic rd_chk(input string name, input logic [1:0] ad, input logic [31:0] exp);
        bus(1'b0, 1'b0, 1'b1, ad, 32'h0);
        idle();
        check({name, "_rdy"}, 32'(rdy_), 32'h0);
        check(name, rd_data, exp);
    endtask

    initial begin
        // Register-access vectors, timer stopped throughout.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd2, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd2, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h2,        1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        1'b0, 32'h2,        1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'hFFFFFFFC, 1'b0, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd1, 32'h1,        1'b0, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'h0,        1'b0, 32'h1,        1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd1, 32'hFFFFFFFE, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd3, 32'h12345678, 1'b0, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd3, 32'h0,        1'b0, 32'h12345678, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h00000055, 1'b1, 32'h0,        1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h00000066, 1'b1, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 2'd2, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h0,        1'b1, 32'h0,        1'b0};

        // Reset state.
        reset = 1'b0;
        idle();
        tick();
        tick();
        check("reset_rdy", 32'(rdy_), 32'h1);
        check("reset_rd", rd_data, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset = 1'b1;
        tick();

        // Table: each access, then one idle cycle that must show no response.
        for (int i = 0; i < 16; i++) begin
            bus(vecs[i].cs_n, vecs[i].as_n, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_rdy", i), 32'(rdy_), 32'(vecs[i].exp_rdy_n));
            check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            idle();
            tick();
            check($sformatf("vec%0d_idle_rdy", i), 32'(rdy_), 32'h1);
            check($sformatf("vec%0d_idle_rd", i), rd_data, 32'h0);
        end

        // One-shot: EXPR=5, START written at edge E0; IRQ rises at E6.
        wr(2'd2, 32'd5);
        wr(2'd3, 32'd0);
        wr(2'd0, 32'h1);
        tick();
        tick();
        rd_chk("oneshot_count_mid", 2'd3, 32'd2);
        check("oneshot_irq_e3", 32'(irq), 32'h0);
        tick();
        tick();
        check("oneshot_irq_e5", 32'(irq), 32'h0);
        tick();
        check("oneshot_irq_e6", 32'(irq), 32'h1);
        rd_chk("oneshot_count_end", 2'd3, 32'd0);
        rd_chk("oneshot_ctrl", 2'd0, 32'h0);
        tick();
        tick();
        rd_chk("oneshot_count_held", 2'd3, 32'd0);
        rd_chk("oneshot_expr", 2'd2, 32'd5);

        // Periodic: EXPR=3, IRQ every 4 cycles; software clear in between.
        wr(2'd1, 32'h0);
        check("per_irq_clr0", 32'(irq), 32'h0);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h3);
        tick();
        tick();
        tick();
        check("per_irq_e3", 32'(irq), 32'h0);
        tick();
        check("per_irq_e4", 32'(irq), 32'h1);
        wr(2'd1, 32'h0);
        check("per_clr_rdy", 32'(rdy_), 32'h0);
        check("per_clr_rd", rd_data, 32'h0);
        check("per_irq_e5", 32'(irq), 32'h0);
        tick();
        tick();
        check("per_irq_e7", 32'(irq), 32'h0);
        tick();
        check("per_irq_e8", 32'(irq), 32'h1);
        rd_chk("per_ctrl", 2'd0, 32'h3);
        rd_chk("per_count", 2'd3, 32'd1);
        tick();
        // INTR clear lands on the expiry edge: the expiry set wins.
        wr(2'd1, 32'h0);
        check("prio_irq_expiry_wins", 32'(irq), 32'h1);

        // Near-wrap expiry after a COUNT write on a running timer.
        wr(2'd1, 32'h0);
        check("wrap_irq_clr", 32'(irq), 32'h0);
        wr(2'd2, 32'hFFFFFFFF);
        wr(2'd3, 32'hFFFFFFFE);
        tick();
        check("wrap_irq_e1", 32'(irq), 32'h0);
        tick();
        check("wrap_irq_e2", 32'(irq), 32'h1);
        rd_chk("wrap_count", 2'd3, 32'd0);
        tick();

        // Read, then reset asserted together with a write: pending ready dropped.
        rd_chk("pre_reset_ctrl", 2'd0, 32'h3);
        reset = 1'b0;
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'h3);
        check("reset_mid_rdy", 32'(rdy_), 32'h1);
        check("reset_mid_rd", rd_data, 32'h0);
        check("reset_mid_irq", 32'(irq), 32'h0);
        reset = 1'b1;
        idle();
        rd_chk("post_reset_ctrl", 2'd0, 32'h0);
        rd_chk("post_reset_intr", 2'd1, 32'h0);
        rd_chk("post_reset_expr", 2'd2, 32'h0);
        rd_chk("post_reset_count", 2'd3, 32'h0);

        // EXPR=0 while running: expiry every cycle, COUNT pinned at 0.
        wr(2'd0, 32'h3);
        check("zero_irq_e0", 32'(irq), 32'h0);
        tick();
        check("zero_irq_e1", 32'(irq), 32'h1);
        rd_chk("zero_count", 2'd3, 32'd0);
        wr(2'd1, 32'h0);
        check("zero_irq_held", 32'(irq), 32'h1);
        wr(2'd0, 32'h0);
        wr(2'd1, 32'h0);
        check("zero_irq_cleared", 32'(irq), 32'h0);

        // Counter wraps through zero without expiry: no IRQ.
        wr(2'd2, 32'd5);
        wr(2'd3, 32'hFFFFFFFE);
        wr(2'd0, 32'h1);
        tick();
        tick();
        check("nowrap_irq_e2", 32'(irq), 32'h0);
        tick();
        check("nowrap_irq_e3", 32'(irq), 32'h0);
        rd_chk("nowrap_count", 2'd3, 32'd1);

        // Back-to-back reads keep ready low, one response per access.
        bus(1'b0, 1'b0, 1'b1, 2'd2, 32'h0);
        check("b2b_rdy0", 32'(rdy_), 32'h0);
        check("b2b_rd0", rd_data, 32'd5);
        bus(1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
        check("b2b_rdy1", 32'(rdy_), 32'h0);
        check("b2b_rd1", rd_data, 32'h1);
        idle();
        tick();
        check("b2b_idle_rdy", 32'(rdy_), 32'h1);
        check("b2b_idle_rd", rd_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 Parameter ADDR_W, default 30, word-address width of the bus slave port (3 chip-select bits + 27 offset bits).
REQ-002 Parameter DATA_W, default 32, word-data width of the bus.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 cs_  input  1  active-low chip select from bus address decoder.
REQ-006 as_  input  1  active-low address strobe from bus.
REQ-007 rw  input  1  access direction; READ=1, WRITE=0.
REQ-008 addr  input  2  register index, bits [1:0] of the bus word address s_addr.
REQ-009 wr_data  input  DATA_W  write data from bus.
REQ-010 rd_data  output  DATA_W  read data to bus read multiplexer.
REQ-011 rdy_  output  1  active-low ready to bus.
REQ-012 irq  output  1  active-high interrupt request, level, equals stored IRQ flag.

Function
REQ-013 Access accepted in any cycle with cs_=0 and as_=0; no other cycle changes register state via the bus.
REQ-014 Register map: 0=CTRL {bit1 PERIODIC, bit0 START}; 1=INTR {bit0 IRQ}; 2=EXPR (32-bit expiry value); 3=COUNT (32-bit counter); unused CTRL/INTR bits read 0, writes ignored.
REQ-015 Write: register updated on the clk edge ending the accepted cycle.
REQ-016 Read: rd_data and rdy_ are registered; rdy_=0 and rd_data=register value (pre-write state of that cycle) in the cycle after acceptance, exactly one cycle per access.
REQ-017 Write acknowledge: rdy_=0 in the cycle after acceptance, rd_data=0.
REQ-018 When rdy_=1, rd_data=0.
REQ-019 Back-to-back accepted cycles each produce one rdy_ pulse, one cycle later; rdy_ may stay 0 continuously.
REQ-020 Counting: while START=1, COUNT increments by 1 per cycle, mod 2^32.
REQ-021 Expiry: when START=1 and COUNT==EXPR, next cycle COUNT=0 and IRQ=1; if PERIODIC=0, START cleared same edge.
REQ-022 EXPR=0 with START=1: expiry every cycle, COUNT stays 0.
REQ-023 START=0: COUNT holds; IRQ holds.
REQ-024 INTR write: IRQ <= wr_data[0]; writing 1 sets IRQ (software test).
REQ-025 Priority same edge: expiry set of IRQ beats bus write clearing IRQ.
REQ-026 Priority same edge: bus write to COUNT beats increment/expiry clear; bus write to CTRL beats one-shot START clear.
REQ-027 Expiry compare uses COUNT before any same-cycle write.
REQ-028 COUNT wrap 0xFFFFFFFF->0 without expiry raises no IRQ.

Reset
REQ-029 On reset=0 at posedge clk: CTRL=0, INTR=0, EXPR=0, COUNT=0, rd_data=0, rdy_=1, irq=0.
REQ-030 Reset mid-access: pending rdy_ pulse is dropped; rdy_=1 the cycle after reset.
REQ-031 Reset has priority over all bus writes and expiry.

Verification
REQ-032 Write EXPR=5, CTRL=0x1 -> COUNT 0..5, irq=1 one cycle after COUNT==5, COUNT=0, START=0, counting stops.
REQ-033 Write EXPR=3, CTRL=0x3 -> irq set every 4 cycles; write INTR=0 clears irq; read CTRL returns 0x3.
REQ-034 Read EXPR after writing 0xDEADBEEF -> rdy_=0 exactly one cycle after accept, rd_data=0xDEADBEEF; rdy_=1 and rd_data=0 next cycle.
REQ-035 Write INTR=0 in same cycle as expiry -> irq=1 afterwards.
REQ-036 Running periodic timer, EXPR=0xFFFFFFFF, write COUNT=0xFFFFFFFE -> expiry after 2 cycles; reset=0 mid-count -> all registers 0, irq=0, rdy_=1.
REQ-037 cs_=0 with as_=1, or as_=0 with cs_=1 -> no register change, rdy_ stays 1.
